// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed four-digit display scanner: SHOW/BLANK slots per digit, a shadow register
// for new values, and commits only at frame boundaries so a frame never shows mixed data.
module digit_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP         = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        blank_lz,
    output logic [3:0]  char_out,
    output logic [3:0]  an,
    output logic        load_ack,
    output logic        pending
);

    localparam int MAXV  = (REFRESH_DIV > GAP) ? REFRESH_DIV : GAP;
    localparam int CNT_W = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(GAP - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      display_q, display_d;
    logic [15:0]      shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       char_q, char_d;
    logic             commit;
    logic [3:1]       lz;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        commit    = (state_q == S_IDLE) ||
                    (state_q == S_BLANK && idx_q == 2'd3 && cnt_q == BLANK_LAST);

        case (state_q)
            S_IDLE: begin
                idx_d = 2'd0;
                cnt_d = '0;
                if (enable) state_d = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end

        // A load landing on a commit point bypasses the shadow entirely.
        if (commit) begin
            if (load) begin
                display_d = data_in;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end else if (pending_q) begin
                display_d = shadow_q;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end
        end else if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end
    end

    // Outputs are built from next-state values so the registered an/char_out line up with state_q.
    always_comb begin
        lz[3] = (display_d[15:12] == 4'd0);
        lz[2] = lz[3] && (display_d[11:8] == 4'd0);
        lz[1] = lz[2] && (display_d[7:4] == 4'd0);
        an_d   = 4'b1111;
        char_d = char_q;
        if (state_d == S_SHOW) begin
            char_d = display_d[{idx_d, 2'b00} +: 4];
            if (!(blank_lz && idx_d != 2'd0 && lz[idx_d])) begin
                an_d = ~(4'b0001 << idx_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            display_q <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            an_q      <= 4'b1111;
            char_q    <= 4'h0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            display_q <= display_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            an_q      <= an_d;
            char_q    <= char_d;
        end
    end

    assign an       = an_q;
    assign char_out = char_q;
    assign load_ack = ack_q;
    assign pending  = pending_q;

endmodule
